// File: rtl/ysyx_25040129_lsu_pkg.sv
// Shared definitions for the LSU: sideband widths, memop field layout,
// access sizes, FSM state encoding and the alignment rule.
package ysyx_25040129_lsu_pkg;

  // Sideband widths (register index and CSR address)
  localparam int unsigned RegsDig = 5;
  localparam int unsigned CsrDig  = 12;

  // memop layout: [4]=mem, [3]=store, [2]=unsigned load, [1:0]=size
  localparam int unsigned MemopW        = 5;
  localparam int unsigned MemopMem      = 4;
  localparam int unsigned MemopStore    = 3;
  localparam int unsigned MemopUnsigned = 2;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StResp = 2'b10,
    StOut  = 2'b11
  } lsu_state_e;

  // Size code 2'b11 is treated like a word everywhere in the LSU.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SizeHalf) begin
      mis = addr_lo[0];
    end else if (size[1]) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_25040129_lsu_align.sv
// Combinational data alignment for the LSU: load extract/extend from the
// bus word and store data replication plus byte-mask generation.
module ysyx_25040129_lsu_align
  import ysyx_25040129_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  store_mask
);

  logic [31:0] shifted;
  logic        sign_bit;

  // Load path: shift the addressed byte lane down, then extend
  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    sign_bit  = 1'b0;
    load_data = rdata;
    if (size == SizeByte) begin
      sign_bit  = ~is_unsigned & shifted[7];
      load_data = {{24{sign_bit}}, shifted[7:0]};
    end else if (size == SizeHalf) begin
      sign_bit  = ~is_unsigned & shifted[15];
      load_data = {{16{sign_bit}}, shifted[15:0]};
    end
  end

  // Store path: replicate data across lanes; mask bits past lane 3 fall off
  always_comb begin
    store_data = wdata;
    store_mask = 4'b1111;
    if (size == SizeByte) begin
      store_data = {4{wdata[7:0]}};
      store_mask = 4'b0001 << addr_lo;
    end else if (size == SizeHalf) begin
      store_data = {2{wdata[15:0]}};
      store_mask = 4'b0011 << addr_lo;
    end
  end

endmodule

// File: rtl/ysyx_25040129_lsu.sv
// Load/store unit between EXU and WBU. Non-memory ops pass straight to the
// output stage; memory ops issue one bus request and wait for its response.
// Optional access-fault checking is enabled with YSYX_25040129_LSU_FAULT_CHK_EN.
module ysyx_25040129_lsu
  import ysyx_25040129_lsu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               is_req_valid_from_exu,
  output logic               is_req_ready_to_exu,
  input  logic [31:0]        addr_in_lsu,
  input  logic [31:0]        wdata_in_lsu,
  input  logic [MemopW-1:0]  memop_in_lsu,
  input  logic [RegsDig-1:0] rd_in_lsu,
  input  logic [CsrDig-1:0]  csr_addr_in_lsu,
  input  logic               reg_write_in_lsu,
  input  logic               csr_write_in_lsu,
  output logic               is_req_valid_to_wbu,
  input  logic               is_req_ready_from_wbu,
  output logic [31:0]        result_out_lsu,
  output logic [RegsDig-1:0] rd_out_lsu,
  output logic [CsrDig-1:0]  csr_addr_out_lsu,
  output logic               reg_write_out_lsu,
  output logic               csr_write_out_lsu,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [31:0]        mem_addr,
  output logic               mem_wen,
  output logic [31:0]        mem_wdata,
  output logic [3:0]         mem_wmask,
  input  logic               mem_resp_valid,
  input  logic [31:0]        mem_resp_data,
  input  logic               mem_resp_err
`ifdef YSYX_25040129_LSU_FAULT_CHK_EN
  ,
  output logic               fault_out_lsu
`endif
);

  lsu_state_e state_q, state_d, accept_target;

  logic               accept;
  logic               accept_fault;
  logic               fault_active;
  logic               resp_take;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [MemopW-1:0]  memop_q;
  logic [RegsDig-1:0] rd_q;
  logic [CsrDig-1:0]  csr_addr_q;
  logic               reg_write_q;
  logic               csr_write_q;
  logic [31:0]        result_q;
  logic [31:0]        load_data;
  logic [31:0]        store_data;
  logic [3:0]         store_mask;
  logic               unused_memop_mem;

  assign accept    = is_req_valid_from_exu & is_req_ready_to_exu;
  assign resp_take = (state_q == StResp) & mem_resp_valid;

  // The mem bit only steers the FSM at accept time; the latched copy is unused.
  assign unused_memop_mem = memop_q[MemopMem];

`ifdef YSYX_25040129_LSU_FAULT_CHK_EN
  logic fault_q;

  assign accept_fault = memop_in_lsu[MemopMem]
                      & is_misaligned(memop_in_lsu[1:0], addr_in_lsu[1:0]);
  assign fault_active = fault_q;
  assign fault_out_lsu = is_req_valid_to_wbu & fault_q;

  // Fault flag: set on a misaligned accept or an erroring response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= accept_fault;
    end else if (resp_take && mem_resp_err) begin
      fault_q <= 1'b1;
    end
  end
`else
  logic unused_resp_err;

  assign accept_fault    = 1'b0;
  assign fault_active    = 1'b0;
  assign unused_resp_err = mem_resp_err;
`endif

  ysyx_25040129_lsu_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (memop_q[1:0]),
    .is_unsigned (memop_q[MemopUnsigned]),
    .rdata       (mem_resp_data),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_data  (store_data),
    .store_mask  (store_mask)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a faulting access bypasses the bus entirely
  always_comb begin
    accept_target = (memop_in_lsu[MemopMem] && !accept_fault) ? StReq : StOut;
    state_d       = state_q;
    unique case (state_q)
      StIdle: if (is_req_valid_from_exu) state_d = accept_target;
      StReq:  if (mem_req_ready) state_d = StResp;
      StResp: if (mem_resp_valid) state_d = StOut;
      StOut: begin
        if (is_req_ready_from_wbu) begin
          state_d = is_req_valid_from_exu ? accept_target : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: everything keyed off state so reset clears them at once
  always_comb begin
    is_req_ready_to_exu = ~reset & ((state_q == StIdle) |
                                    ((state_q == StOut) & is_req_ready_from_wbu));
    is_req_valid_to_wbu = (state_q == StOut);
    mem_req_valid       = (state_q == StReq);
    mem_addr            = mem_req_valid ? addr_q : 32'h0;
    mem_wen             = mem_req_valid & memop_q[MemopStore];
    mem_wdata           = mem_wen ? store_data : 32'h0;
    mem_wmask           = mem_wen ? store_mask : 4'h0;
    result_out_lsu      = result_q;
    rd_out_lsu          = rd_q;
    csr_addr_out_lsu    = csr_addr_q;
    reg_write_out_lsu   = is_req_valid_to_wbu & reg_write_q & ~fault_active;
    csr_write_out_lsu   = is_req_valid_to_wbu & csr_write_q;
  end

  // Operand latch; loads overwrite the result when the response lands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      memop_q     <= '0;
      rd_q        <= '0;
      csr_addr_q  <= '0;
      reg_write_q <= 1'b0;
      csr_write_q <= 1'b0;
      result_q    <= 32'h0;
    end else if (accept) begin
      addr_q      <= addr_in_lsu;
      wdata_q     <= wdata_in_lsu;
      memop_q     <= memop_in_lsu;
      rd_q        <= rd_in_lsu;
      csr_addr_q  <= csr_addr_in_lsu;
      reg_write_q <= reg_write_in_lsu;
      csr_write_q <= csr_write_in_lsu;
      result_q    <= addr_in_lsu;
    end else if (resp_take && !memop_q[MemopStore]) begin
      result_q    <= load_data;
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Self-checking bench for ysyx_25040129_lsu: directed cases plus randomized
// ops against a behavioural model. Define YSYX_25040129_LSU_FAULT_CHK_EN to
// also exercise fault checking.
module tb_ysyx_25040129_lsu;
  import ysyx_25040129_lsu_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               is_req_valid_from_exu;
  logic               is_req_ready_to_exu;
  logic [31:0]        addr_in_lsu;
  logic [31:0]        wdata_in_lsu;
  logic [MemopW-1:0]  memop_in_lsu;
  logic [RegsDig-1:0] rd_in_lsu;
  logic [CsrDig-1:0]  csr_addr_in_lsu;
  logic               reg_write_in_lsu;
  logic               csr_write_in_lsu;
  logic               is_req_valid_to_wbu;
  logic               is_req_ready_from_wbu;
  logic [31:0]        result_out_lsu;
  logic [RegsDig-1:0] rd_out_lsu;
  logic [CsrDig-1:0]  csr_addr_out_lsu;
  logic               reg_write_out_lsu;
  logic               csr_write_out_lsu;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [31:0]        mem_addr;
  logic               mem_wen;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_wmask;
  logic               mem_resp_valid;
  logic [31:0]        mem_resp_data;
  logic               mem_resp_err;
`ifdef YSYX_25040129_LSU_FAULT_CHK_EN
  logic               fault_out_lsu;
`endif

  int checks = 0;
  int errors = 0;

  ysyx_25040129_lsu dut (
    .clock                 (clock),
    .reset                 (reset),
    .is_req_valid_from_exu (is_req_valid_from_exu),
    .is_req_ready_to_exu   (is_req_ready_to_exu),
    .addr_in_lsu           (addr_in_lsu),
    .wdata_in_lsu          (wdata_in_lsu),
    .memop_in_lsu          (memop_in_lsu),
    .rd_in_lsu             (rd_in_lsu),
    .csr_addr_in_lsu       (csr_addr_in_lsu),
    .reg_write_in_lsu      (reg_write_in_lsu),
    .csr_write_in_lsu      (csr_write_in_lsu),
    .is_req_valid_to_wbu   (is_req_valid_to_wbu),
    .is_req_ready_from_wbu (is_req_ready_from_wbu),
    .result_out_lsu        (result_out_lsu),
    .rd_out_lsu            (rd_out_lsu),
    .csr_addr_out_lsu      (csr_addr_out_lsu),
    .reg_write_out_lsu     (reg_write_out_lsu),
    .csr_write_out_lsu     (csr_write_out_lsu),
    .mem_req_valid         (mem_req_valid),
    .mem_req_ready         (mem_req_ready),
    .mem_addr              (mem_addr),
    .mem_wen               (mem_wen),
    .mem_wdata             (mem_wdata),
    .mem_wmask             (mem_wmask),
    .mem_resp_valid        (mem_resp_valid),
    .mem_resp_data         (mem_resp_data),
    .mem_resp_err          (mem_resp_err)
`ifdef YSYX_25040129_LSU_FAULT_CHK_EN
    ,
    .fault_out_lsu         (fault_out_lsu)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: pick the addressed lane with arithmetic, then extend
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [4:0] memop);
    logic [31:0] v;
    v = data / (32'd1 << ((addr % 4) * 8));
    if (memop[1:0] == 2'd0) begin
      v = v % 256;
      if (!memop[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (memop[1:0] == 2'd1) begin
      v = v % 65536;
      if (!memop[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = data;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic [4:0] memop);
    if (memop[1:0] == 2'd0) return (w % 256) * 32'h0101_0101;
    if (memop[1:0] == 2'd1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_wmask(input logic [31:0] addr, input logic [4:0] memop);
    int a;
    a = int'(addr % 4);
    if (memop[1:0] == 2'd0) return (32'd1 << a) % 16;
    if (memop[1:0] == 2'd1) return (32'd3 << a) % 16;
    return 32'd15;
  endfunction

  function automatic logic model_misaligned(input logic [31:0] addr, input logic [4:0] memop);
    if (memop[1:0] == 2'd1) return (addr % 2) != 0;
    if (memop[1:0] >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  // One full transaction from an idle LSU, starting just after a negedge.
  task automatic run_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] memop, input logic [4:0] rd, input logic [11:0] csr,
                        input logic regw, input logic csrw, input int req_wait,
                        input int resp_wait, input logic [31:0] rdata, input logic rerr);
    int   lat;
    int   exp_lat;
    logic exp_fault;
    logic skip;
    logic [31:0] exp_res;
    skip = 1'b0;
    exp_fault = 1'b0;
`ifdef YSYX_25040129_LSU_FAULT_CHK_EN
    skip = memop[4] && model_misaligned(addr, memop);
    exp_fault = skip || (memop[4] && rerr);
`endif
    is_req_valid_from_exu = 1'b1;
    addr_in_lsu = addr;  wdata_in_lsu = wdata;  memop_in_lsu = memop;
    rd_in_lsu = rd;  csr_addr_in_lsu = csr;
    reg_write_in_lsu = regw;  csr_write_in_lsu = csrw;
    #1 chk({tag, ".ready_to_exu"}, 32'(is_req_ready_to_exu), 32'd1);
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    // Scramble inputs so the outputs must come from the latched copy
    is_req_valid_from_exu = 1'b0;
    addr_in_lsu = $urandom;  wdata_in_lsu = $urandom;  memop_in_lsu = 5'($urandom);
    rd_in_lsu = 5'($urandom);  csr_addr_in_lsu = 12'($urandom);
    reg_write_in_lsu = 1'($urandom);  csr_write_in_lsu = 1'($urandom);
    #1;
    if (memop[4] && !skip) begin
      for (int i = 0; i <= req_wait; i++) begin
        mem_req_ready = (i == req_wait);
        #1;
        chk({tag, ".req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, ".mem_addr"}, mem_addr, addr);
        chk({tag, ".mem_wen"}, 32'(mem_wen), 32'(memop[3]));
        if (memop[3]) begin
          chk({tag, ".mem_wdata"}, mem_wdata, model_wdata(wdata, memop));
          chk({tag, ".mem_wmask"}, 32'(mem_wmask), model_wmask(addr, memop));
        end
        @(posedge clock);
        lat++;
        @(negedge clock);
      end
      mem_req_ready = 1'b0;
      #1 chk({tag, ".req_dropped"}, 32'(mem_req_valid), 32'd0);
      for (int i = 0; i <= resp_wait; i++) begin
        mem_resp_valid = (i == resp_wait);
        mem_resp_data  = (i == resp_wait) ? rdata : $urandom;
        mem_resp_err   = (i == resp_wait) ? rerr : 1'b0;
        #1 chk({tag, ".wbu_wait"}, 32'(is_req_valid_to_wbu), 32'd0);
        @(posedge clock);
        lat++;
        @(negedge clock);
      end
      mem_resp_valid = 1'b0;  mem_resp_err = 1'b0;  mem_resp_data = $urandom;
      exp_lat = 1 + (req_wait + 1) + (resp_wait + 1);
    end else begin
      chk({tag, ".no_req"}, 32'(mem_req_valid), 32'd0);
      exp_lat = 1;
    end
    #1;
    exp_res = (memop[4] && !memop[3]) ? model_load(addr, rdata, memop) : addr;
    chk({tag, ".valid_to_wbu"}, 32'(is_req_valid_to_wbu), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    if (!exp_fault) chk({tag, ".result"}, result_out_lsu, exp_res);
    chk({tag, ".rd"}, 32'(rd_out_lsu), 32'(rd));
    chk({tag, ".csr_addr"}, 32'(csr_addr_out_lsu), 32'(csr));
    chk({tag, ".reg_write"}, 32'(reg_write_out_lsu), 32'(regw && !exp_fault));
    chk({tag, ".csr_write"}, 32'(csr_write_out_lsu), 32'(csrw));
`ifdef YSYX_25040129_LSU_FAULT_CHK_EN
    chk({tag, ".fault"}, 32'(fault_out_lsu), 32'(exp_fault));
`endif
    // Result must hold while WBU stalls
    @(posedge clock);
    @(negedge clock);
    #1 chk({tag, ".hold_valid"}, 32'(is_req_valid_to_wbu), 32'd1);
    if (!exp_fault) chk({tag, ".hold_result"}, result_out_lsu, exp_res);
    is_req_ready_from_wbu = 1'b1;
    @(posedge clock);
    @(negedge clock);
    is_req_ready_from_wbu = 1'b0;
    #1 chk({tag, ".drained"}, 32'(is_req_valid_to_wbu), 32'd0);
    chk({tag, ".regw_idle"}, 32'(reg_write_out_lsu), 32'd0);
  endtask

  logic [31:0] b2b_addr[8];
  logic [4:0]  b2b_rd[8];
  logic        b2b_regw[8];

  initial begin
    logic [4:0]  mop;
    logic [31:0] a;
    reset = 1'b1;
    is_req_valid_from_exu = 1'b0;  is_req_ready_from_wbu = 1'b0;
    addr_in_lsu = '0;  wdata_in_lsu = '0;  memop_in_lsu = '0;
    rd_in_lsu = '0;  csr_addr_in_lsu = '0;  reg_write_in_lsu = 1'b0;  csr_write_in_lsu = 1'b0;
    mem_req_ready = 1'b0;  mem_resp_valid = 1'b0;  mem_resp_data = '0;  mem_resp_err = 1'b0;

    #2;
    chk("rst.ready_to_exu", 32'(is_req_ready_to_exu), 32'd0);
    chk("rst.valid_to_wbu", 32'(is_req_valid_to_wbu), 32'd0);
    chk("rst.mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst.result", result_out_lsu, 32'd0);
    chk("rst.reg_write", 32'(reg_write_out_lsu), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1 chk("idle.ready_to_exu", 32'(is_req_ready_to_exu), 32'd1);

    // Directed cases
    run_op("alu", 32'h0000_1234, 32'h0, 5'b00000, 5'd5, 12'h300, 1'b1, 1'b0, 0, 0, 32'h0, 1'b0);
    run_op("lb", 32'h8000_0003, 32'h0, 5'b10000, 5'd7, 12'h0, 1'b1, 1'b0, 0, 0,
           32'h80FF_FFFF, 1'b0);
    run_op("lbu", 32'h8000_0003, 32'h0, 5'b10100, 5'd8, 12'h0, 1'b1, 1'b0, 1, 2,
           32'h80FF_FFFF, 1'b0);
    run_op("sh", 32'h8000_0002, 32'hABCD_1234, 5'b11001, 5'd0, 12'h0, 1'b0, 1'b0, 3, 1,
           32'h0, 1'b0);
    run_op("lhs", 32'h8000_0002, 32'h0, 5'b10001, 5'd9, 12'h0, 1'b1, 1'b0, 0, 0,
           32'h9876_5432, 1'b0);
    run_op("sw", 32'h8000_0010, 32'hDEAD_BEEF, 5'b11010, 5'd0, 12'h0, 1'b0, 1'b1, 0, 0,
           32'h0, 1'b0);
`ifdef YSYX_25040129_LSU_FAULT_CHK_EN
    run_op("lw_mis", 32'h8000_0002, 32'h0, 5'b10010, 5'd3, 12'h0, 1'b1, 1'b0, 0, 0,
           32'h0, 1'b0);
    run_op("lw_err", 32'h8000_0004, 32'h0, 5'b10010, 5'd3, 12'h0, 1'b1, 1'b0, 0, 1,
           32'h1111_2222, 1'b1);
`endif

    // Randomized ops, naturally aligned so both builds expect a clean access
    for (int n = 0; n < 24; n++) begin
      mop = 5'($urandom);
      if (mop[1:0] == 2'b11) mop[1:0] = 2'b10;
      a = $urandom;
      if (mop[4] && mop[1:0] == 2'b01) a[0] = 1'b0;
      if (mop[4] && mop[1]) a[1:0] = 2'b00;
      run_op($sformatf("rnd%0d", n), a, $urandom, mop, 5'($urandom), 12'($urandom),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), $urandom, 1'b0);
    end

    // Reset while waiting for a response; a late response must be ignored
    is_req_valid_from_exu = 1'b1;
    addr_in_lsu = 32'h8000_0020;  memop_in_lsu = 5'b10010;  reg_write_in_lsu = 1'b1;
    @(posedge clock);
    @(negedge clock);
    is_req_valid_from_exu = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_resp.ready_to_exu", 32'(is_req_ready_to_exu), 32'd0);
    chk("rst_resp.mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_resp.mem_addr", mem_addr, 32'd0);
    chk("rst_resp.result", result_out_lsu, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mem_resp_valid = 1'b1;  mem_resp_data = 32'h5555_AAAA;
    @(posedge clock);
    @(negedge clock);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_resp.no_valid", 32'(is_req_valid_to_wbu), 32'd0);
      chk("rst_resp.no_req", 32'(mem_req_valid), 32'd0);
      chk("rst_resp.idle_ready", 32'(is_req_ready_to_exu), 32'd1);
      @(negedge clock);
    end

    // Back-to-back ALU ops with WBU always ready: one result per cycle
    for (int i = 0; i < 8; i++) begin
      b2b_addr[i] = $urandom;  b2b_rd[i] = 5'($urandom);  b2b_regw[i] = 1'($urandom);
    end
    is_req_ready_from_wbu = 1'b1;
    is_req_valid_from_exu = 1'b1;
    memop_in_lsu = 5'b00000;  csr_write_in_lsu = 1'b0;
    addr_in_lsu = b2b_addr[0];  rd_in_lsu = b2b_rd[0];  reg_write_in_lsu = b2b_regw[0];
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      #1;
      chk($sformatf("b2b%0d.valid", i), 32'(is_req_valid_to_wbu), 32'd1);
      chk($sformatf("b2b%0d.result", i), result_out_lsu, b2b_addr[i]);
      chk($sformatf("b2b%0d.rd", i), 32'(rd_out_lsu), 32'(b2b_rd[i]));
      chk($sformatf("b2b%0d.regw", i), 32'(reg_write_out_lsu), 32'(b2b_regw[i]));
      chk($sformatf("b2b%0d.ready", i), 32'(is_req_ready_to_exu), 32'd1);
      if (i < 7) begin
        addr_in_lsu = b2b_addr[i+1];  rd_in_lsu = b2b_rd[i+1];
        reg_write_in_lsu = b2b_regw[i+1];
      end else begin
        is_req_valid_from_exu = 1'b0;
      end
    end
    @(posedge clock);
    @(negedge clock);
    #1 chk("b2b.drained", 32'(is_req_valid_to_wbu), 32'd0);
    is_req_ready_from_wbu = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
